// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums a stream of unsigned PW-bit products into an AW-bit accumulator.
//   When the beat flagged last is accepted, it registers the group result
//   (sum modulo 2^AW, saturating beat count, sticky overflow) and presents it
//   on an output valid/ready handshake. While a result is pending, no input
//   is accepted.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream product valid
//   in_ready   block accepts a product this cycle (depends on state and rst only)
//   in_p       product value, unsigned, PW bits
//   in_last    final product of the current group, qualified by in_valid
//   out_valid  group result available
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum modulo 2^AW
//   out_count  number of products in the group (saturates at 2^CW-1)
//   out_ovf    sum exceeded 2^AW-1 at some point during the group
module product_accumulator #(
  parameter int PW = 4,
  parameter int AW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_p,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [CW-1:0] out_count,
  output logic          out_ovf
);

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] acc_reg, acc_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic [AW-1:0] out_sum_reg, out_sum_next;
  logic [CW-1:0] out_count_reg, out_count_next;
  logic          out_ovf_reg, out_ovf_next;

  // Product zero-extended to AW+1 bits so the top bit of the add is the carry.
  logic [AW:0]   in_p_ext;
  logic [AW:0]   sum_wide;
  logic [CW-1:0] count_inc;
  logic          accept;

  for (genvar gi = 0; gi <= AW; gi++) begin : g_ext
    if (gi < PW) begin : g_bit
      assign in_p_ext[gi] = in_p[gi];
    end else begin : g_zero
      assign in_p_ext[gi] = 1'b0;
    end
  end

  assign sum_wide  = {1'b0, acc_reg} + in_p_ext;
  assign count_inc = (count_reg == {CW{1'b1}}) ? count_reg : count_reg + 1'b1;

  // in_ready is a pure function of state and rst; out_ready never reaches it.
  assign in_ready  = (state_reg == ACC) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == HOLD);
  assign out_sum   = out_sum_reg;
  assign out_count = out_count_reg;
  assign out_ovf   = out_ovf_reg;

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    count_next     = count_reg;
    ovf_next       = ovf_reg;
    out_sum_next   = out_sum_reg;
    out_count_next = out_count_reg;
    out_ovf_next   = out_ovf_reg;
    case (state_reg)
      ACC: begin
        if (accept) begin
          acc_next   = sum_wide[AW-1:0];
          ovf_next   = ovf_reg | sum_wide[AW];
          count_next = count_inc;
          if (in_last) begin
            // Result registers take the post-accept values of this beat.
            out_sum_next   = sum_wide[AW-1:0];
            out_count_next = count_inc;
            out_ovf_next   = ovf_reg | sum_wide[AW];
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = ACC;
        end
      end
      default: state_next = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACC;
      acc_reg       <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
      out_ovf_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      count_reg     <= count_next;
      ovf_reg       <= ovf_next;
      out_sum_reg   <= out_sum_next;
      out_count_reg <= out_count_next;
      out_ovf_reg   <= out_ovf_next;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (PW=4, AW=8, CW=8).
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_p;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [7:0] out_count;
  logic       out_ovf;

  int checks = 0;
  int errors = 0;

  product_accumulator #(.PW(4), .AW(8), .CW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          len;
    logic [15:0] vals;   // beat b in vals[4*b +: 4]
    int          sum;
    int          cnt;
    int          ovf;
  } vec_t;

  vec_t vecs[5];

  // Advance to just after the next rising edge; outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Idle cycles with junk on the data lines; none of it may be accepted.
  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_p    = 4'($urandom_range(0, 15));
      in_last = 1'($urandom_range(0, 1));
      tick();
    end
    in_last = 1'b0;
  endtask

  // Offer one beat and hold it until accepted (bounded wait).
  task automatic beat(input logic [3:0] p, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_wait: in_ready stuck at 0 for %0d cycles, expected 1", n);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat's accept edge: result must already be
  // valid. Stalls downstream for 'stall' cycles, then completes the handshake.
  task automatic expect_result(input string name, input int sum, input int cnt,
                               input int ovf, input int stall);
    check({name, "_valid_latency"}, 32'(out_valid), 32'd1);
    check({name, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({name, "_stall_valid"}, 32'(out_valid), 32'd1);
      check({name, "_stall_sum"}, 32'(out_sum), 32'(sum));
      check({name, "_stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    check({name, "_sum"}, 32'(out_sum), 32'(sum));
    check({name, "_count"}, 32'(out_count), 32'(cnt));
    check({name, "_ovf"}, 32'(out_ovf), 32'(ovf));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, len, accepts, pv, stall;

    vecs[0] = '{"plan3",   3, 16'h0961, 16, 3, 0};
    vecs[1] = '{"zero1",   1, 16'h0000,  0, 1, 0};
    vecs[2] = '{"max4",    4, 16'hFFFF, 60, 4, 0};
    vecs[3] = '{"pair",    2, 16'h0032,  5, 2, 0};
    vecs[4] = '{"single4", 1, 16'h0004,  4, 1, 0};

    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven groups.
    foreach (vecs[i]) begin
      for (int b = 0; b < vecs[i].len; b++)
        beat(vecs[i].vals[4*b +: 4], 1'(b == vecs[i].len - 1));
      expect_result(vecs[i].name, vecs[i].sum, vecs[i].cnt, vecs[i].ovf, 0);
    end

    // Backpressure with beats offered during HOLD; they must not be taken.
    beat(4'd2, 1'b0);
    beat(4'd3, 1'b1);
    in_valid = 1'b1; in_p = 4'd7; in_last = 1'b1;
    expect_result("bp", 5, 2, 0, 5);
    in_valid = 1'b0;
    beat(4'd4, 1'b1);
    expect_result("bp_after", 4, 1, 0, 0);

    // Overflow: 29 x 9 = 261, then the flag must clear for the next group.
    for (int b = 0; b < 29; b++) beat(4'd9, 1'(b == 28));
    expect_result("ovf29", 5, 29, 1, 0);
    beat(4'd4, 1'b1);
    expect_result("ovf_clear", 4, 1, 0, 0);

    // Count saturation: 260 beats of 1 -> sum 4, count 255, overflow.
    for (int b = 0; b < 260; b++) beat(4'd1, 1'(b == 259));
    expect_result("sat", 4, 255, 1, 0);

    // Back-to-back single-beat groups: one accept every two cycles.
    accepts = 0;
    in_valid = 1'b1; in_p = 4'd0; in_last = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (in_valid && in_ready) accepts++;
      if (out_valid) begin
        check("b2b_sum", 32'(out_sum), 32'd0);
        check("b2b_count", 32'(out_count), 32'd1);
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'd5);
    check("b2b_end_state", 32'(in_ready), 32'd1);

    // Gapped input: valid pattern 1,0,0,1,1 with 6,x,x,2,4.
    in_valid = 1'b1; in_p = 4'd6;  in_last = 1'b0; tick();
    in_valid = 1'b0; in_p = 4'd15; in_last = 1'b1; tick();
    in_valid = 1'b0; in_p = 4'd15; in_last = 1'b1; tick();
    in_valid = 1'b1; in_p = 4'd2;  in_last = 1'b0; tick();
    in_valid = 1'b1; in_p = 4'd4;  in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    expect_result("gap", 12, 3, 0, 0);

    // Reset mid-group discards the partial sum.
    beat(4'd6, 1'b0);
    beat(4'd9, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    beat(4'd3, 1'b1);
    expect_result("rst_mid_next", 3, 1, 0, 0);

    // Reset while a result is pending.
    beat(4'd5, 1'b1);
    check("rst_hold_pre", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_hold_valid", 32'(out_valid), 32'd0);
    check("rst_hold_sum", 32'(out_sum), 32'd0);
    rst = 1'b0;
    tick();
    beat(4'd3, 1'b1);
    expect_result("rst_hold_next", 3, 1, 0, 0);

    // Randomized groups against an arithmetic model of the group result.
    for (int g = 0; g < 30; g++) begin
      len   = $urandom_range(1, 40);
      total = 0;
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        pv = $urandom_range(0, 15);
        total += pv;
        beat(4'(pv), 1'(b == len - 1));
      end
      stall = $urandom_range(0, 3);
      expect_result($sformatf("rand%0d", g), total % 256, (len > 255) ? 255 : len,
                    (total > 255) ? 1 : 0, stall);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
